// File: rtl/dest_reg_tracker_if.sv
// Pipeline-side bundle for the destination-register tracker.
// Master drives EX/ID state; slave returns MEM/WB state, forwarding and stall.
interface dest_reg_tracker_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [31:0]       ex_dest;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              flush;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_reg_write;
  logic [REG_AW-1:0] wb_dest;
  logic              wb_reg_write;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output ex_dest, ex_reg_write, ex_mem_read,
    output ex_rs, ex_rt, id_rs, id_rt,
    output id_uses_rt, flush,
    input  mem_dest, mem_reg_write,
    input  wb_dest, wb_reg_write,
    input  fwd_a, fwd_b, stall, stall_count
  );

  modport slave (
    input  ex_dest, ex_reg_write, ex_mem_read,
    input  ex_rs, ex_rt, id_rs, id_rt,
    input  id_uses_rt, flush,
    output mem_dest, mem_reg_write,
    output wb_dest, wb_reg_write,
    output fwd_a, fwd_b, stall, stall_count
  );
endinterface

// File: rtl/dest_reg_tracker.sv
// Carries the write destination from EX through MEM/WB and derives
// operand forwarding selects plus the single-cycle load-use stall.
module dest_reg_tracker #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic              Clk,
  input logic              Reset,
  dest_reg_tracker_if.slave bus
);

  logic [REG_AW-1:0] ex_idx;
  logic              eff_we;
  logic              unused_hi;

  logic [REG_AW-1:0] mem_dest_q;
  logic              mem_we_q;
  logic [REG_AW-1:0] wb_dest_q;
  logic              wb_we_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        fwd_a_c;
  logic [1:0]        fwd_b_c;
  logic              stall_c;
  logic              hit_rs;
  logic              hit_rt;

  assign ex_idx    = bus.ex_dest[REG_AW-1:0];
  assign unused_hi = ^bus.ex_dest[31:REG_AW];

  // A $0 write or a flushed slot becomes a bubble, so $0 never reaches WB
  assign eff_we = bus.ex_reg_write
               && (ex_idx != '0)
               && !bus.flush;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_dest_q <= '0;
      mem_we_q   <= 1'b0;
      wb_dest_q  <= '0;
      wb_we_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mem_dest_q <= eff_we ? ex_idx : '0;
      mem_we_q   <= eff_we;
      wb_dest_q  <= mem_dest_q;
      wb_we_q    <= mem_we_q;
      if (stall_c && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_rs = (ex_idx == bus.id_rs);
  assign hit_rt = bus.id_uses_rt
               && (ex_idx == bus.id_rt);

  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    stall_c = 1'b0;
    if (!Reset) begin
      // MEM holds the younger result, so it wins over WB
      if (mem_we_q && (mem_dest_q == bus.ex_rs)) begin
        fwd_a_c = 2'b10;
      end else if (wb_we_q && (wb_dest_q == bus.ex_rs)) begin
        fwd_a_c = 2'b01;
      end
      if (mem_we_q && (mem_dest_q == bus.ex_rt)) begin
        fwd_b_c = 2'b10;
      end else if (wb_we_q && (wb_dest_q == bus.ex_rt)) begin
        fwd_b_c = 2'b01;
      end
      stall_c = bus.ex_mem_read
             && eff_we
             && (hit_rs || hit_rt);
    end
  end

  assign bus.mem_dest      = mem_dest_q;
  assign bus.mem_reg_write = mem_we_q;
  assign bus.wb_dest       = wb_dest_q;
  assign bus.wb_reg_write  = wb_we_q;
  assign bus.fwd_a         = fwd_a_c;
  assign bus.fwd_b         = fwd_b_c;
  assign bus.stall         = stall_c;
  assign bus.stall_count   = cnt_q;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed bench for dest_reg_tracker, built with a 4-bit stall counter
// so saturation is reachable in a handful of cycles.
module tb_dest_reg_tracker;

  localparam int AW = 5;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  dest_reg_tracker_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  dest_reg_tracker #(.REG_AW(AW), .CNT_W(CW)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_dest      = '0;
    bus.ex_reg_write = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_rs        = '0;
    bus.ex_rt        = '0;
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_uses_rt   = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] outs;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.ex_dest      = $urandom;
      bus.ex_reg_write = 1'b1;
      bus.ex_mem_read  = 1'b1;
      bus.ex_rs        = AW'($urandom);
      bus.ex_rt        = AW'($urandom);
      bus.id_rs        = AW'($urandom);
      bus.id_rt        = AW'($urandom);
      bus.id_uses_rt   = 1'b1;
      bus.flush        = 1'b0;
      @(negedge clk);
      outs = {bus.mem_dest, bus.mem_reg_write,
              bus.wb_dest, bus.wb_reg_write,
              bus.fwd_a, bus.fwd_b, bus.stall,
              bus.stall_count};
      n_cmp++;
      if (outs !== '0) begin
        n_err++;
        $display("FAIL reset_outs[%0d]: got %h want 0",
                 i, outs);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.stall_count !== 4'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0",
               bus.stall_count);
    end
    step();
  endtask

  task automatic test_forward();
    idle();
    bus.ex_dest      = 32'd9;
    bus.ex_reg_write = 1'b1;
    step();
    idle();
    bus.ex_rs = 5'd9;
    @(negedge clk);
    n_cmp++;
    if (bus.fwd_a !== 2'b10) begin
      n_err++;
      $display("FAIL fwd_a_mem: got %b want 10",
               bus.fwd_a);
    end
    n_cmp++;
    if ({bus.mem_dest, bus.mem_reg_write} !== {5'd9, 1'b1}) begin
      n_err++;
      $display("FAIL mem_dest9: got %0d/%b want 9/1",
               bus.mem_dest, bus.mem_reg_write);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.fwd_a !== 2'b01) begin
      n_err++;
      $display("FAIL fwd_a_wb: got %b want 01",
               bus.fwd_a);
    end
    n_cmp++;
    if ({bus.wb_dest, bus.wb_reg_write} !== {5'd9, 1'b1}) begin
      n_err++;
      $display("FAIL wb_dest9: got %0d/%b want 9/1",
               bus.wb_dest, bus.wb_reg_write);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.fwd_a !== 2'b00) begin
      n_err++;
      $display("FAIL fwd_a_none: got %b want 00",
               bus.fwd_a);
    end
    step();
  endtask

  task automatic test_load_use();
    idle();
    bus.ex_dest      = 32'd4;
    bus.ex_reg_write = 1'b1;
    bus.ex_mem_read  = 1'b1;
    bus.id_rs        = 5'd2;
    bus.id_rt        = 5'd4;
    bus.id_uses_rt   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.stall, bus.stall_count} !== {1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL stall_rt: got %b/%0d want 1/0",
               bus.stall, bus.stall_count);
    end
    step();
    bus.id_uses_rt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.stall, bus.stall_count} !== {1'b0, 4'd1}) begin
      n_err++;
      $display("FAIL stall_no_rt: got %b/%0d want 0/1",
               bus.stall, bus.stall_count);
    end
    step();
    bus.id_rs = 5'd4;
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_err++;
      $display("FAIL stall_rs: got %b want 1",
               bus.stall);
    end
    step();
    idle();
    @(negedge clk);
    n_cmp++;
    if ({bus.stall, bus.stall_count} !== {1'b0, 4'd2}) begin
      n_err++;
      $display("FAIL stall_idle: got %b/%0d want 0/2",
               bus.stall, bus.stall_count);
    end
    step();
  endtask

  task automatic test_jal();
    idle();
    bus.ex_dest      = 32'h0000_001F;
    bus.ex_reg_write = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_dest, bus.mem_reg_write} !== {5'd31, 1'b1}) begin
      n_err++;
      $display("FAIL jal_mem: got %0d/%b want 31/1",
               bus.mem_dest, bus.mem_reg_write);
    end
    bus.ex_dest = 32'hFFFF_FFE0;
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.wb_dest, bus.wb_reg_write} !== {5'd31, 1'b1}) begin
      n_err++;
      $display("FAIL jal_wb: got %0d/%b want 31/1",
               bus.wb_dest, bus.wb_reg_write);
    end
    n_cmp++;
    if ({bus.mem_dest, bus.mem_reg_write} !== 6'd0) begin
      n_err++;
      $display("FAIL zero_bubble: got %0d/%b want 0/0",
               bus.mem_dest, bus.mem_reg_write);
    end
    idle();
    step();
  endtask

  task automatic test_flush();
    idle();
    bus.ex_dest      = 32'd6;
    bus.ex_reg_write = 1'b1;
    bus.ex_mem_read  = 1'b1;
    bus.id_rs        = 5'd6;
    bus.flush        = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall: got %b want 0",
               bus.stall);
    end
    step();
    idle();
    bus.ex_rs = 5'd6;
    bus.ex_rt = 5'd6;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL flush_mem_we: got %b want 0",
               bus.mem_reg_write);
    end
    n_cmp++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_fwd: got %b/%b want 00/00",
               bus.fwd_a, bus.fwd_b);
    end
    n_cmp++;
    if (bus.stall_count !== 4'd2) begin
      n_err++;
      $display("FAIL flush_count: got %0d want 2",
               bus.stall_count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    bus.ex_dest      = 32'd7;
    bus.ex_reg_write = 1'b1;
    step();
    step();
    idle();
    bus.ex_rs = 5'd7;
    bus.ex_rt = 5'd7;
    @(negedge clk);
    n_cmp++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b1010) begin
      n_err++;
      $display("FAIL b2b_mem_pri: got %b/%b want 10/10",
               bus.fwd_a, bus.fwd_b);
    end
    bus.ex_rt = 5'd3;
    #1;
    n_cmp++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b1000) begin
      n_err++;
      $display("FAIL b2b_rt_miss: got %b/%b want 10/00",
               bus.fwd_a, bus.fwd_b);
    end
    step();
  endtask

  task automatic test_saturate();
    int exp_cnt;
    exp_cnt = 2;
    idle();
    bus.ex_dest      = 32'd5;
    bus.ex_reg_write = 1'b1;
    bus.ex_mem_read  = 1'b1;
    bus.id_rs        = 5'd5;
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.stall, bus.stall_count} !== {1'b1, 4'(exp_cnt)}) begin
        n_err++;
        $display("FAIL sat_cnt[%0d]: got %b/%0d want 1/%0d",
                 i, bus.stall, bus.stall_count, exp_cnt);
      end
      step();
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.stall_count !== 4'd15) begin
      n_err++;
      $display("FAIL sat_final: got %0d want 15",
               bus.stall_count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [20:0] outs;
    idle();
    bus.ex_dest      = 32'd12;
    bus.ex_reg_write = 1'b1;
    step();
    bus.ex_dest = 32'd13;
    step();
    rst = 1'b1;
    bus.ex_rs = 5'd12;
    bus.ex_rt = 5'd13;
    step();
    @(negedge clk);
    outs = {bus.mem_dest, bus.mem_reg_write,
            bus.wb_dest, bus.wb_reg_write,
            bus.fwd_a, bus.fwd_b, bus.stall,
            bus.stall_count};
    n_cmp++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got %h want 0", outs);
    end
    step();
    rst = 1'b0;
    idle();
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_jal();
    test_flush();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
